// File: rtl/zf_preprocess_scheduler.sv
// Sequencer for the 2x2 MIMO ZF preprocess engine: buffers invQ matrices, pairs
// each with SYMS_PER_MAT symbol vectors, issues one op at a time, returns results.
//
// state  | meaning
// IDLE   | no op in flight, waiting for a matrix and a symbol
// ISSUE  | operands presented to the engine, waiting for pp_accept_out
// WAIT   | engine working, watchdog counting down
// OUT    | result held on out_data until out_ready
module zf_preprocess_scheduler #(
  parameter int MAT_DEPTH    = 4,
  parameter int SYMS_PER_MAT = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         mat_wr_valid,
  input  logic [255:0] mat_wr_data,
  output logic         mat_wr_ready,
  input  logic         sym_valid,
  input  logic [127:0] sym_y,
  input  logic [127:0] sym_n,
  output logic         sym_ready,
  output logic         pp_enable,
  output logic         pp_accept_in,
  input  logic         pp_accept_out,
  input  logic         pp_ready_out,
  output logic [127:0] pp_y,
  output logic [127:0] pp_n,
  output logic [255:0] pp_invQ,
  input  logic [127:0] pp_q,
  output logic         out_valid,
  output logic [127:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         err_timeout
);

  localparam int PW = $clog2(MAT_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = (SYMS_PER_MAT > 1) ? $clog2(SYMS_PER_MAT) : 1;
  localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_OUT} state_t;

  state_t         state_q, state_d;
  logic [255:0]   mem_q [MAT_DEPTH];
  logic [255:0]   mem_d [MAT_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic [SW-1:0]  sym_cnt_q, sym_cnt_d;
  logic [WW-1:0]  wd_q, wd_d;
  logic [127:0]   pp_y_q, pp_y_d, pp_n_q, pp_n_d;
  logic [127:0]   out_data_q, out_data_d;
  logic           out_valid_q, out_valid_d;
  logic           pp_enable_q, pp_enable_d;
  logic           pp_accept_in_q, pp_accept_in_d;
  logic           err_q, err_d;

  logic sym_take, accept, pop, push;

  // mat_wr_ready looks only at the registered count, so a push at full is
  // refused even when a pop happens in the same cycle.
  assign mat_wr_ready = (count_q != CW'(MAT_DEPTH));
  assign push         = mat_wr_valid && mat_wr_ready;
  assign sym_take     = (count_q != '0) && sym_valid &&
                        ((state_q == S_IDLE) || ((state_q == S_OUT) && out_ready));
  assign accept       = (state_q == S_ISSUE) && pp_accept_out;
  assign pop          = accept && (sym_cnt_q == SW'(SYMS_PER_MAT - 1));

  assign sym_ready    = sym_take;
  assign pp_invQ      = mem_q[rd_ptr_q];
  assign pp_y         = pp_y_q;
  assign pp_n         = pp_n_q;
  assign pp_enable    = pp_enable_q;
  assign pp_accept_in = pp_accept_in_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign busy         = (state_q != S_IDLE);
  assign err_timeout  = err_q;

  always_comb begin
    state_d        = state_q;
    mem_d          = mem_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    count_d        = count_q;
    sym_cnt_d      = sym_cnt_q;
    wd_d           = wd_q;
    pp_y_d         = pp_y_q;
    pp_n_d         = pp_n_q;
    out_data_d     = out_data_q;
    out_valid_d    = out_valid_q;
    pp_enable_d    = pp_enable_q;
    pp_accept_in_d = pp_accept_in_q;
    err_d          = err_q;

    if (push) begin
      mem_d[wr_ptr_q] = mat_wr_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (accept) begin
      sym_cnt_d = pop ? '0 : sym_cnt_q + 1'b1;
    end
    if (sym_take) begin
      pp_y_d = sym_y;
      pp_n_d = sym_n;
    end

    case (state_q)
      S_IDLE: begin
        if (sym_take) begin
          state_d        = S_ISSUE;
          pp_enable_d    = 1'b1;
          pp_accept_in_d = 1'b1;
        end
      end
      S_ISSUE: begin
        if (accept) begin
          state_d        = S_WAIT;
          pp_accept_in_d = 1'b0;
          wd_d           = WW'(TIMEOUT - 2);
        end
      end
      S_WAIT: begin
        if (pp_ready_out) begin
          state_d     = S_OUT;
          out_data_d  = pp_q;
          out_valid_d = 1'b1;
          pp_enable_d = 1'b0;
        end else if (wd_q == '0) begin
          state_d     = S_IDLE;
          err_d       = 1'b1;
          pp_enable_d = 1'b0;
        end else begin
          wd_d = wd_q - 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (sym_take) begin
            state_d        = S_ISSUE;
            pp_enable_d    = 1'b1;
            pp_accept_in_d = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      for (int i = 0; i < MAT_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      sym_cnt_q      <= '0;
      wd_q           <= '0;
      pp_y_q         <= '0;
      pp_n_q         <= '0;
      out_data_q     <= '0;
      out_valid_q    <= 1'b0;
      pp_enable_q    <= 1'b0;
      pp_accept_in_q <= 1'b0;
      err_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_q          <= mem_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      sym_cnt_q      <= sym_cnt_d;
      wd_q           <= wd_d;
      pp_y_q         <= pp_y_d;
      pp_n_q         <= pp_n_d;
      out_data_q     <= out_data_d;
      out_valid_q    <= out_valid_d;
      pp_enable_q    <= pp_enable_d;
      pp_accept_in_q <= pp_accept_in_d;
      err_q          <= err_d;
    end
  end

endmodule

// File: tb/tb_zf_preprocess_scheduler.sv
// Bench for zf_preprocess_scheduler: behavioural engine, transaction-level model
// of matrix buffer and op lifecycle, directed scenarios and a random phase.
module tb_zf_preprocess_scheduler;
  localparam int D   = 4;
  localparam int SPM = 8;
  localparam int TO  = 64;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         mat_wr_valid = 1'b0;
  logic [255:0] mat_wr_data = '0;
  logic         mat_wr_ready;
  logic         sym_valid = 1'b0;
  logic [127:0] sym_y = '0;
  logic [127:0] sym_n = '0;
  logic         sym_ready;
  logic         pp_enable, pp_accept_in;
  logic         pp_accept_out = 1'b0;
  logic         pp_ready_out = 1'b0;
  logic [127:0] pp_y, pp_n;
  logic [255:0] pp_invQ;
  logic [127:0] pp_q = '0;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_ready = 1'b0;
  logic         busy, err_timeout;

  zf_preprocess_scheduler #(.MAT_DEPTH(D), .SYMS_PER_MAT(SPM), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .mat_wr_valid(mat_wr_valid), .mat_wr_data(mat_wr_data), .mat_wr_ready(mat_wr_ready),
    .sym_valid(sym_valid), .sym_y(sym_y), .sym_n(sym_n), .sym_ready(sym_ready),
    .pp_enable(pp_enable), .pp_accept_in(pp_accept_in), .pp_accept_out(pp_accept_out),
    .pp_ready_out(pp_ready_out), .pp_y(pp_y), .pp_n(pp_n), .pp_invQ(pp_invQ), .pp_q(pp_q),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [127:0] r128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [255:0] r256();
    return {r128(), r128()};
  endfunction

  // Engine: takes operands when idle, answers y^n after a chosen latency.
  int           acc_pct  = 100;
  int           eng_lmin = 3;
  int           eng_lmax = 3;
  bit           eng_never = 1'b0;
  bit           eng_pend  = 1'b0;
  int           eng_due   = 0;
  logic [127:0] eng_res   = '0;

  always @(posedge clk) begin
    #1;
    pp_ready_out = 1'b0;
    pp_q         = r128();
    if (eng_pend && !eng_never && cyc >= eng_due) begin
      pp_ready_out = 1'b1;
      pp_q         = eng_res;
      eng_pend     = 1'b0;
    end
    pp_accept_out = !eng_pend && (int'($urandom_range(99, 0)) < acc_pct);
    if (pp_accept_out && pp_accept_in) begin
      eng_pend = 1'b1;
      eng_res  = pp_y ^ pp_n;
      eng_due  = cyc + int'($urandom_range(eng_lmax, eng_lmin));
    end
  end

  // Reference model: matrix queue, op lifecycle (0 none, 1 issued, 2 in engine,
  // 3 result held), expected results.
  logic [255:0] mq[$];
  logic [255:0] opq[$];
  logic [127:0] resq[$];
  int           stage = 0;
  int           wdc = 0;
  int           acc_cnt = 0;
  bit           m_err = 1'b0;

  always @(negedge clk) begin
    bit           sr, m_push, m_pop;
    logic [255:0] op;
    if (cyc >= 1) begin
      sr     = sym_valid && (mq.size() > 0) && (stage == 0 || (stage == 3 && out_ready));
      m_push = mat_wr_valid && (mq.size() < D);
      m_pop  = 1'b0;
      chk("mat_wr_ready", mat_wr_ready, mq.size() < D);
      chk("sym_ready", sym_ready, sr);
      chk("busy", busy, stage != 0);
      chk("out_valid", out_valid, stage == 3);
      chk("pp_accept_in", pp_accept_in, stage == 1);
      chk("pp_enable", pp_enable, stage == 1 || stage == 2);
      chk("err_timeout", err_timeout, m_err);
      if (stage == 3 && resq.size() > 0) chk("out_data", out_data, resq[0]);
      if (reset) begin
        mq.delete(); opq.delete(); resq.delete();
        stage = 0; wdc = 0; acc_cnt = 0; m_err = 1'b0;
      end else begin
        case (stage)
          0: if (sr) begin opq.push_back({sym_y, sym_n}); stage = 1; end
          1: if (pp_accept_out) begin
               op = opq.pop_front();
               chk("pp_y", pp_y, op[255:128]);
               chk("pp_n", pp_n, op[127:0]);
               if (mq.size() > 0) chk("pp_invQ", pp_invQ, mq[0]);
               resq.push_back(op[255:128] ^ op[127:0]);
               acc_cnt++;
               if (acc_cnt % SPM == 0) m_pop = 1'b1;
               wdc = 0;
               stage = 2;
             end
          2: if (pp_ready_out) stage = 3;
             else begin
               wdc++;
               if (wdc == TO - 1) begin
                 m_err = 1'b1;
                 stage = 0;
                 void'(resq.pop_back());
               end
             end
          3: if (out_ready) begin
               void'(resq.pop_front());
               if (sr) begin opq.push_back({sym_y, sym_n}); stage = 1; end
               else stage = 0;
             end
          default: stage = 0;
        endcase
        if (m_pop && mq.size() > 0) void'(mq.pop_front());
        if (m_push) mq.push_back(mat_wr_data);
      end
    end
  end

  logic [127:0] last_xor = '0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mat(input logic [255:0] m);
    mat_wr_valid = 1'b1;
    mat_wr_data  = m;
    tick();
    mat_wr_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) tick();
    reset = 1'b0;
  endtask

  task automatic stream(input int n);
    int sent = 0;
    int k = 0;
    bit hs;
    sym_valid = 1'b1;
    sym_y = r128();
    sym_n = r128();
    while (sent < n && k < 400) begin
      @(negedge clk);
      hs = sym_ready;
      k++;
      tick();
      if (hs) begin
        sent++;
        last_xor = sym_y ^ sym_n;
        sym_y = r128();
        sym_n = r128();
      end
      if (sent >= n) sym_valid = 1'b0;
    end
    sym_valid = 1'b0;
    chk("stream_sent", 256'(sent), 256'(n));
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    sym_valid = 1'b0;
    @(negedge clk);
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("drain_idle", busy, 1'b0);
    tick();
  endtask

  logic [255:0] m0, m1;
  int t0, ta, te, k;

  initial begin
    // T1: reset held three cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t1_mat_wr_ready", mat_wr_ready, 1'b1);
    chk("t1_busy", busy, 1'b0);
    chk("t1_flags", {out_valid, pp_enable, pp_accept_in, err_timeout, sym_ready}, 5'b0);
    chk("t1_out_data", out_data, 128'h0);
    chk("t1_pp_yn", {pp_y, pp_n}, 256'h0);
    chk("t1_invq", pp_invQ, 256'h0);
    tick();
    reset = 1'b0;

    // T2: single op, 3-cycle engine
    acc_pct = 100; eng_lmin = 3; eng_lmax = 3;
    m0 = r256();
    write_mat(m0);
    sym_valid = 1'b1;
    sym_y = 128'h1000_8333_0333_1000_0333_04CC_84CC_0333;
    sym_n = 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000;
    @(negedge clk);
    chk("t2_sym_ready", sym_ready, 1'b1);
    t0 = cyc;
    tick();
    sym_valid = 1'b0;
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    chk("t2_latency", 256'(cyc - t0), 256'(5));
    chk("t2_out_data", out_data, 128'hEFFF_8333_FCCC_1000_FCCC_04CC_7B33_0333);
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // T3: two matrices, sixteen symbols
    do_reset(2);
    m0 = r256(); m1 = r256();
    write_mat(m0);
    write_mat(m1);
    out_ready = 1'b1; acc_pct = 60; eng_lmin = 1; eng_lmax = 4;
    stream(16);
    drain();
    sym_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_empty_sym_ready", sym_ready, 1'b0);
      tick();
    end
    sym_valid = 1'b0;

    // T4: fill beyond depth, then downstream backpressure
    out_ready = 1'b0;
    mat_wr_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mat_wr_data = r256();
      @(negedge clk);
      chk("t4_wr_ready", mat_wr_ready, i < 4);
      tick();
    end
    mat_wr_valid = 1'b0;
    stream(1);
    k = 0;
    @(negedge clk);
    while (!out_valid && k < 30) begin @(negedge clk); k++; end
    tick();
    sym_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", out_valid, 1'b1);
      chk("t4_hold_data", out_data, last_xor);
      chk("t4_hold_enable", pp_enable, 1'b0);
      chk("t4_hold_sym_ready", sym_ready, 1'b0);
      tick();
    end
    out_ready = 1'b1;
    stream(8);
    drain();

    // T5: engine never answers
    do_reset(1);
    m0 = r256(); m1 = r256();
    write_mat(m0);
    write_mat(m1);
    out_ready = 1'b1; acc_pct = 100; eng_lmin = 2; eng_lmax = 2;
    stream(6);
    drain();
    eng_never = 1'b1;
    stream(1);
    k = 0;
    @(negedge clk);
    while (!(pp_accept_in && pp_accept_out) && k < 10) begin @(negedge clk); k++; end
    ta = cyc;
    k = 0;
    while (!err_timeout && k < 100) begin @(negedge clk); k++; end
    te = cyc;
    chk("t5_timeout_cycle", 256'(te - ta), 256'(TO));
    chk("t5_idle", {busy, out_valid}, 2'b00);
    chk("t5_invq_held", pp_invQ, m0);
    tick();
    eng_pend = 1'b0;
    eng_never = 1'b0;
    stream(1);
    drain();
    chk("t5_invq_next", pp_invQ, m1);
    chk("t5_err_sticky", err_timeout, 1'b1);

    // Random phase
    acc_pct = 60; eng_lmin = 1; eng_lmax = 6;
    for (int i = 0; i < 400; i++) begin
      mat_wr_valid = ($urandom_range(9, 0) < 3);
      mat_wr_data  = r256();
      out_ready    = $urandom_range(1, 0);
      sym_valid    = ($urandom_range(9, 0) < 6);
      sym_y        = r128();
      sym_n        = r128();
      tick();
    end
    mat_wr_valid = 1'b0;
    drain();

    // T6: reset while the engine is working, late answer ignored
    acc_pct = 100; eng_lmin = 12; eng_lmax = 12;
    write_mat(r256());
    stream(1);
    k = 0;
    @(negedge clk);
    while (!(busy && !pp_accept_in && !out_valid) && k < 10) begin @(negedge clk); k++; end
    chk("t6_in_wait", {busy, pp_accept_in, out_valid}, 3'b100);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sym_valid = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("t6_busy", busy, 1'b0);
      chk("t6_out_valid", out_valid, 1'b0);
      chk("t6_sym_ready", sym_ready, 1'b0);
      tick();
    end
    sym_valid = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    failures++;
    $display("FAIL global_time_limit cycle %0d: got running expected done", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "time limit reached");
  end

endmodule
